// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: sends cmd, addr and a 32-bit payload (LSB byte first,
// MSB bit first) and captures the MISO payload. Defining SPI_FRAME_MASTER_CRC_EN
// appends a CRC-8 (poly 0x07) byte computed over the first six bytes.
module spi_frame_master #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned SS_GAP  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  cmd,
   input  logic [7:0]  addr,
   input  logic [31:0] data,
   output logic        busy,
   output logic        done,
   output logic [31:0] rx_data,
   output logic [7:0]  crc_out,
   output logic        spi_sck,
   output logic        spi_so,
   input  logic        spi_si,
   output logic        spi_ss
);

`ifdef SPI_FRAME_MASTER_CRC_EN
   localparam int unsigned NumBytes    = 7;
   localparam int unsigned PayloadBits = 48;
   // Bit count at the falling edge that ends the last payload bit.
   localparam logic [5:0]  CrcBit      = 6'd48;
`else
   localparam int unsigned NumBytes    = 6;
`endif
   localparam int unsigned NumBits = NumBytes * 8;
   localparam logic [5:0]  BitEnd  = 6'(NumBits);
   localparam logic [5:0]  RxFirst = 6'd16;
   localparam logic [5:0]  RxLast  = 6'd47;
   localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);
   localparam logic [7:0]  GapLast = 8'(SS_GAP - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StShift,
      StHold,
      StGap
   } state_t;

   state_t               state_q;
   logic [7:0]           div_cnt_q;
   // Number of rising spi_sck edges issued in this frame (0..NumBits).
   logic [5:0]           bit_cnt_q;
   logic [NumBits-1:0]   tx_sr_q;
   logic [NumBits-1:0]   tx_load;
   logic [NumBits-1:0]   tx_shift;
   logic [31:0]          rx_sr_q;
   logic [31:0]          rx_data_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 sck_q;
   logic                 ss_q;
   logic                 div_last;
   logic                 sck_rise;
   logic                 done_set;
`ifdef SPI_FRAME_MASTER_CRC_EN
   logic [7:0]           crc_q;
   logic [7:0]           crc_next;
   logic [7:0]           crc_out_q;
`endif

   // Phase timing strobes shared by the FSM, receive shifter and CRC.
   always_comb begin
      div_last = (div_cnt_q == DivLast);
      sck_rise = ((state_q == StSetup) && div_last) ||
                 ((state_q == StShift) && !sck_q && div_last && (bit_cnt_q != BitEnd));
      // done marks the final GAP cycle; with a one-cycle gap that is its first cycle.
      done_set = ((state_q == StHold) && div_last && (GapLast == 8'd0)) ||
                 ((state_q == StGap) && (GapLast != 8'd0) && (div_cnt_q == GapLast - 8'd1));
   end

   // Frame image loaded on start, and the next transmit shift value.
   always_comb begin
`ifdef SPI_FRAME_MASTER_CRC_EN
      tx_load  = {cmd, addr, data[7:0], data[15:8], data[23:16], data[31:24], 8'h00};
      tx_shift = {tx_sr_q[NumBits-2:0], 1'b0};
      // CRC is final once the last payload bit has been sampled.
      if (bit_cnt_q == CrcBit) begin
         tx_shift = {crc_q, {PayloadBits{1'b0}}};
      end
`else
      tx_load  = {cmd, addr, data[7:0], data[15:8], data[23:16], data[31:24]};
      tx_shift = {tx_sr_q[NumBits-2:0], 1'b0};
`endif
   end

   // Frame sequencer with registered SPI pins and status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sck_q     <= 1'b0;
         ss_q      <= 1'b1;
      end else begin
         done_q <= done_set;
         if (done_set) begin
            rx_data_q <= {rx_sr_q[7:0], rx_sr_q[15:8], rx_sr_q[23:16], rx_sr_q[31:24]};
         end
         if (sck_rise && (bit_cnt_q >= RxFirst) && (bit_cnt_q <= RxLast)) begin
            rx_sr_q <= {rx_sr_q[30:0], spi_si};
         end
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  tx_sr_q   <= tx_load;
                  busy_q    <= 1'b1;
                  ss_q      <= 1'b0;
                  div_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  state_q   <= StSetup;
               end
            end
            StSetup: begin
               if (div_last) begin
                  div_cnt_q <= '0;
                  sck_q     <= 1'b1;
                  bit_cnt_q <= bit_cnt_q + 6'd1;
                  state_q   <= StShift;
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
            StShift: begin
               if (!div_last) begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end else begin
                  div_cnt_q <= '0;
                  if (sck_q) begin
                     sck_q   <= 1'b0;
                     tx_sr_q <= tx_shift;
                  end else if (bit_cnt_q == BitEnd) begin
                     state_q <= StHold;
                  end else begin
                     sck_q     <= 1'b1;
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                  end
               end
            end
            StHold: begin
               if (div_last) begin
                  div_cnt_q <= '0;
                  ss_q      <= 1'b1;
                  state_q   <= StGap;
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
            StGap: begin
               if (div_cnt_q == GapLast) begin
                  div_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= StIdle;
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef SPI_FRAME_MASTER_CRC_EN
   // Bit-serial CRC-8 over the transmitted payload bits.
   always_comb begin
      crc_next = {crc_q[6:0], 1'b0} ^ ({8{crc_q[7] ^ tx_sr_q[NumBits-1]}} & 8'h07);
   end

   // CRC accumulator, cleared per frame, published with done.
   always_ff @(posedge clk) begin
      if (!rst) begin
         crc_q     <= '0;
         crc_out_q <= '0;
      end else begin
         if ((state_q == StIdle) && start) begin
            crc_q <= '0;
         end else if (sck_rise && (bit_cnt_q < CrcBit)) begin
            crc_q <= crc_next;
         end
         if (done_set) begin
            crc_out_q <= crc_q;
         end
      end
   end

   assign crc_out = crc_out_q;
`else
   assign crc_out = 8'h00;
`endif

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign spi_sck = sck_q;
   assign spi_so  = tx_sr_q[NumBits-1];
   assign spi_ss  = ss_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master (default parameters), built with or
// without SPI_FRAME_MASTER_CRC_EN.
module tb_spi_frame_master;

   localparam int CLK_DIV = 4;
   localparam int SS_GAP  = 2;
`ifdef SPI_FRAME_MASTER_CRC_EN
   localparam int NBYTES = 7;
   localparam bit CRC_ON = 1'b1;
`else
   localparam int NBYTES = 6;
   localparam bit CRC_ON = 1'b0;
`endif
   localparam int NBITS      = NBYTES * 8;
   localparam int EXP_SS_LOW = (NBYTES == 7) ? 456 : 392;
   localparam int TIMEOUT    = 3000;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [31:0] miso;     // payload the slave returns, also the expected rx_data
      logic [7:0]  exp_crc;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  cmd;
   logic [7:0]  addr;
   logic [31:0] data;
   logic        busy;
   logic        done;
   logic [31:0] rx_data;
   logic [7:0]  crc_out;
   logic        spi_sck;
   logic        spi_so;
   logic        spi_si;
   logic        spi_ss;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Slave-side monitor state.
   logic [55:0] miso_frame = '0;
   logic        mosi_bits[$];
   int          rise_cnt = 0;
   int          done_cnt = 0;
   int          ss_fall_cyc = 0;
   int          ss_rise_cyc = 0;
   int          ss_low_len = 0;
   int          ss_high_len = 0;

   spi_frame_master #(
      .CLK_DIV(CLK_DIV),
      .SS_GAP (SS_GAP)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .cmd    (cmd),
      .addr   (addr),
      .data   (data),
      .busy   (busy),
      .done   (done),
      .rx_data(rx_data),
      .crc_out(crc_out),
      .spi_sck(spi_sck),
      .spi_so (spi_so),
      .spi_si (spi_si),
      .spi_ss (spi_ss)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Byte-at-a-time CRC-8, poly 0x07, init 0, no reflection, no final XOR.
   function automatic logic [7:0] crc8_model(input logic [47:0] bytes);
      logic [7:0] c;
      c = 8'h00;
      for (int b = 0; b < 6; b++) begin
         c = c ^ bytes[47-8*b -: 8];
         for (int k = 0; k < 8; k++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
         end
      end
      return c;
   endfunction

   function automatic logic [47:0] payload_of(input logic [7:0] c, input logic [7:0] a,
                                              input logic [31:0] d);
      return {c, a, d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [7:0] exp_crc_of(input logic [7:0] c, input logic [7:0] a,
                                             input logic [31:0] d);
      return CRC_ON ? crc8_model(payload_of(c, a, d)) : 8'h00;
   endfunction

   // Expected MOSI frame, first transmitted bit in bit 55.
   function automatic logic [55:0] mosi_model(input vec_t v);
      logic [47:0] p;
      p = payload_of(v.cmd, v.addr, v.data);
      return {p, CRC_ON ? crc8_model(p) : 8'h00};
   endfunction

   function automatic logic miso_bit(input int i);
      if (i < NBITS) return miso_frame[55-i];
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic set_miso(input logic [31:0] m);
      miso_frame = {8'($urandom), 8'($urandom), m[7:0], m[15:8], m[23:16], m[31:24],
                    8'($urandom)};
   endtask

   // Mode-0 slave: samples MOSI at sck rise, drives MISO at ss fall / sck fall.
   initial begin
      logic prev_ss;
      logic prev_sck;
      prev_ss  = 1'b1;
      prev_sck = 1'b0;
      spi_si   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (prev_ss && !spi_ss) begin
            ss_high_len = cyc - ss_rise_cyc;
            ss_fall_cyc = cyc;
            rise_cnt    = 0;
            mosi_bits.delete();
            spi_si      = miso_bit(0);
         end
         if (!prev_ss && spi_ss) begin
            ss_low_len  = cyc - ss_fall_cyc;
            ss_rise_cyc = cyc;
         end
         if (!prev_sck && spi_sck) begin
            mosi_bits.push_back(spi_so);
            rise_cnt++;
         end
         if (prev_sck && !spi_sck) spi_si = miso_bit(rise_cnt);
         if (done === 1'b1) done_cnt++;
         prev_ss  = spi_ss;
         prev_sck = spi_sck;
      end
   end

   task automatic launch(input vec_t v);
      @(negedge clk);
      cmd      = v.cmd;
      addr     = v.addr;
      data     = v.data;
      set_miso(v.miso);
      done_cnt = 0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'(1));
      chk("ss_after_start", 64'(spi_ss), 64'(0));
      chk("so_first_bit", 64'(spi_so), 64'(v.cmd[7]));
   endtask

   task automatic finish(input vec_t v, input logic [31:0] prev_rx);
      int          n;
      int          bad;
      logic        held_ok;
      logic [55:0] exp_frame;
      n       = 0;
      held_ok = 1'b1;
      while (done !== 1'b1 && n < TIMEOUT) begin
         if (rx_data !== prev_rx) held_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      if (n >= TIMEOUT) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles", TIMEOUT);
         return;
      end
      chk("rx_hold_before_done", 64'(held_ok), 64'(1));
      chk("rx_data", 64'(rx_data), 64'(v.miso));
      chk("crc_out", 64'(crc_out), 64'(v.exp_crc));
      chk("busy_at_done", 64'(busy), 64'(1));
      chk("ss_at_done", 64'(spi_ss), 64'(1));
      chk("ss_low_cycles", 64'(ss_low_len), 64'(EXP_SS_LOW));
      chk("mosi_len", 64'(mosi_bits.size()), 64'(NBITS));
      exp_frame = mosi_model(v);
      bad = 0;
      for (int i = 0; i < NBITS && i < mosi_bits.size(); i++) begin
         if (mosi_bits[i] !== exp_frame[55-i]) bad++;
      end
      chk("mosi_bit_errors", 64'(bad), 64'(0));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("busy_after_done", 64'(busy), 64'(0));
      chk("done_count", 64'(done_cnt), 64'(1));
      chk("rx_held_after_done", 64'(rx_data), 64'(v.miso));
   endtask

   task automatic wait_rises(input int target);
      int n;
      n = 0;
      while (rise_cnt < target && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      if (n >= TIMEOUT) begin
         checks++;
         errors++;
         $display("FAIL sck_timeout: %0d rising edges seen, wanted %0d", rise_cnt, target);
      end
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      v.cmd     = 8'($urandom);
      v.addr    = 8'($urandom);
      v.data    = $urandom;
      v.miso    = $urandom;
      v.exp_crc = exp_crc_of(v.cmd, v.addr, v.data);
      return v;
   endfunction

   initial begin
      vec_t        vecs[4];
      vec_t        v;
      logic [31:0] prev_rx;

      rst   = 1'b0;
      start = 1'b0;
      cmd   = '0;
      addr  = '0;
      data  = '0;

      vecs[0] = '{cmd: 8'h01, addr: 8'h00, data: 32'h0000_0000, miso: 32'h1234_5678,
                  exp_crc: (CRC_ON ? 8'h29 : 8'h00)};
      vecs[1] = '{cmd: 8'h00, addr: 8'h00, data: 32'h0000_0000, miso: 32'h0000_0000,
                  exp_crc: 8'h00};
      vecs[2] = '{cmd: 8'hFF, addr: 8'hFF, data: 32'hFFFF_FFFF, miso: 32'hFFFF_FFFF,
                  exp_crc: exp_crc_of(8'hFF, 8'hFF, 32'hFFFF_FFFF)};
      vecs[3] = '{cmd: 8'hA5, addr: 8'h3C, data: 32'hDEAD_BEEF, miso: 32'hCAFE_F00D,
                  exp_crc: exp_crc_of(8'hA5, 8'h3C, 32'hDEAD_BEEF)};

      // Reset held for three cycles with start high, then the frame begins.
      repeat (2) @(negedge clk);
      cmd   = vecs[0].cmd;
      addr  = vecs[0].addr;
      data  = vecs[0].data;
      set_miso(vecs[0].miso);
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ss", 64'(spi_ss), 64'(1));
      chk("rst_sck", 64'(spi_sck), 64'(0));
      chk("rst_so", 64'(spi_so), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_rx_data", 64'(rx_data), 64'(0));
      chk("rst_crc_out", 64'(crc_out), 64'(0));
      rst      = 1'b1;
      done_cnt = 0;
      @(negedge clk);
      chk("post_rst_ss", 64'(spi_ss), 64'(0));
      chk("post_rst_busy", 64'(busy), 64'(1));
      start = 1'b0;
      finish(vecs[0], 32'h0);
      prev_rx = vecs[0].miso;

      // Table vectors.
      for (int i = 1; i < 4; i++) begin
         launch(vecs[i]);
         finish(vecs[i], prev_rx);
         prev_rx = vecs[i].miso;
      end

      // Random frames against the model.
      for (int i = 0; i < 4; i++) begin
         v = rand_vec();
         launch(v);
         finish(v, prev_rx);
         prev_rx = v.miso;
      end

      // start pulsed mid-frame with different inputs is ignored.
      v = rand_vec();
      launch(v);
      wait_rises(10);
      @(negedge clk);
      cmd   = ~v.cmd;
      addr  = ~v.addr;
      data  = ~v.data;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_ignore_start", 64'(busy), 64'(1));
      finish(v, prev_rx);
      prev_rx = v.miso;
      repeat (10) @(negedge clk);
      chk("no_extra_frame_ss", 64'(spi_ss), 64'(1));
      chk("no_extra_frame_busy", 64'(busy), 64'(0));

      // start held high: back-to-back frames separated by SS_GAP + 1 idle cycle.
      v = rand_vec();
      @(negedge clk);
      cmd      = v.cmd;
      addr     = v.addr;
      data     = v.data;
      set_miso(v.miso);
      done_cnt = 0;
      start    = 1'b1;
      @(negedge clk);
      chk("held_busy", 64'(busy), 64'(1));
      finish(v, prev_rx);
      done_cnt = 0;
      @(negedge clk);
      chk("held_second_ss", 64'(spi_ss), 64'(0));
      chk("held_second_busy", 64'(busy), 64'(1));
      chk("ss_high_between", 64'(ss_high_len), 64'(SS_GAP + 1));
      start = 1'b0;
      finish(v, v.miso);
      prev_rx = v.miso;

      // Reset at bit 20 aborts the frame.
      v = rand_vec();
      launch(v);
      wait_rises(20);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ss", 64'(spi_ss), 64'(1));
      chk("abort_sck", 64'(spi_sck), 64'(0));
      chk("abort_so", 64'(spi_so), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_rx_data", 64'(rx_data), 64'(0));
      chk("abort_crc_out", 64'(crc_out), 64'(0));
      rst = 1'b1;
      repeat (600) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt), 64'(0));
      chk("abort_ss_idle", 64'(spi_ss), 64'(1));
      chk("abort_rx_stays", 64'(rx_data), 64'(0));

      // Recovery after abort.
      v = rand_vec();
      launch(v);
      finish(v, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_frame_master.md
SPI_FRAME_MASTER -- requirements
Module: spi_frame_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and rst as elsewhere in the codebase.
REQ-002 Parameter CLK_DIV SHALL default to 4 and SHALL set the spi_sck half-period in clk cycles (legal range 2..255).
REQ-003 Parameter SS_GAP SHALL default to 2 and SHALL set the minimum spi_ss-high time in clk cycles between frames (legal range 1..255).
REQ-004 Port clk SHALL be an input, 1 bit: system clock, all logic on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: synchronous reset, active low.
REQ-006 Port start SHALL be an input, 1 bit: frame request, sampled when busy=0.
REQ-007 Port cmd SHALL be an input, 8 bits: command byte, latched on accepted start.
REQ-008 Port addr SHALL be an input, 8 bits: address byte, latched on accepted start.
REQ-009 Port data SHALL be an input, 32 bits: payload, latched on accepted start.
REQ-010 Port busy SHALL be an output, 1 bit: a frame is in progress.
REQ-011 Port done SHALL be an output, 1 bit: one-cycle frame-complete pulse.
REQ-012 Port rx_data SHALL be an output, 32 bits: MISO payload captured during the data bytes.
REQ-013 Port crc_out SHALL be an output, 8 bits: CRC of the last transmitted frame.
REQ-014 Port spi_sck SHALL be an output, 1 bit: SPI clock.
REQ-015 Port spi_so SHALL be an output, 1 bit: MOSI.
REQ-016 Port spi_si SHALL be an input, 1 bit: MISO.
REQ-017 Port spi_ss SHALL be an output, 1 bit: slave select, active low.

Function
REQ-018 The frame byte order SHALL be cmd, addr, data[7:0], data[15:8], data[23:16], data[31:24], then crc; bits SHALL be sent MSB first within each byte.
REQ-019 SPI mode 0 SHALL apply: spi_sck idles low, the slave samples on the rising edge, and spi_so changes only at the spi_ss fall or on a falling edge.
REQ-020 The state machine SHALL have the states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-021 IDLE: start=1 SHALL latch cmd, addr and data, set busy=1 and spi_ss=0, drive bit 7 of cmd onto spi_so, and go to SETUP, all on the next edge.
REQ-022 SETUP SHALL last CLK_DIV cycles with spi_sck low and then go to SHIFT.
REQ-023 SHIFT: each bit SHALL be CLK_DIV cycles with spi_sck high followed by CLK_DIV cycles with spi_sck low; spi_si SHALL be sampled on the clk edge that raises spi_sck; the next bit SHALL be driven on the edge that lowers spi_sck.
REQ-024 After the last falling edge of the last byte, the block SHALL go to HOLD for CLK_DIV cycles and then raise spi_ss.
REQ-025 GAP SHALL last SS_GAP cycles with spi_ss high; on its final cycle done SHALL be 1, and busy SHALL be 0 on the following cycle.
REQ-026 start SHALL be ignored while busy=1; start held high SHALL begin a new frame in the first IDLE cycle.
REQ-027 The MISO bits received during bytes 2..5 SHALL form rx_data in the same byte order as the transmitted data; rx_data SHALL update only in the cycle done=1 and SHALL hold otherwise.
REQ-028 The CRC SHALL be CRC-8 with polynomial 0x07, initial value 0x00, no reflection, no final XOR, computed over bytes 0..5.
REQ-029 crc_out SHALL update in the cycle done=1.
REQ-030 Bit and byte counters SHALL be sized for 7 bytes; no counter SHALL wrap during a frame.
REQ-031 With the defaults, spi_ss SHALL be low for 4 + 56*8 + 4 = 456 cycles.

Reset
REQ-032 While rst=0 at a clk edge, the block SHALL enter IDLE and drive spi_ss=1, spi_sck=0, spi_so=0, busy=0, done=0, rx_data=0 and crc_out=0.
REQ-033 A reset mid-frame SHALL abort the frame on that edge, with no done pulse and no update of rx_data.
REQ-034 rst=0 SHALL take priority over a simultaneous start.

Configuration
REQ-035 With macro SPI_FRAME_MASTER_CRC_EN defined, the frame SHALL be 7 bytes and byte 6 SHALL be the CRC.
REQ-036 Without SPI_FRAME_MASTER_CRC_EN, the frame SHALL be 6 bytes, the CRC logic SHALL be absent, crc_out SHALL be tied to 0, and with the defaults spi_ss SHALL be low for 392 cycles.

Verification
REQ-037 Reset: rst=0 for 3 cycles with start=1, then rst=1 -> all outputs at their reset values, then one frame begins.
REQ-038 Frame, CRC_EN, defaults: cmd=0x01, addr=0x00, data=0 -> MOSI bytes 01 00 00 00 00 00 29, crc_out=0x29, spi_ss low for 456 cycles, one done pulse.
REQ-039 MISO: slave drives bytes xx xx 78 56 34 12 xx -> rx_data=0x12345678 at done, held until the next done.
REQ-040 Busy: start pulsed during SHIFT -> ignored; start held high -> second frame's spi_ss falls after SS_GAP=2 high cycles plus 1 IDLE cycle.
REQ-041 Abort: rst=0 at bit 20 -> spi_ss=1 on the next edge, no done pulse, rx_data unchanged.
REQ-042 CRC_EN undefined, defaults: all-zero frame -> 6 bytes, spi_ss low for 392 cycles, crc_out=0.
